// File: rtl/saturating_accumulator_bank_pkg.sv
// rtl/saturating_accumulator_bank_pkg.sv - shared flag positions and sizing helpers for the accumulator bank
package saturating_accumulator_bank_pkg;

  localparam int FLAG_WIDTH     = 4;
  localparam int FLAG_AT_MAX    = 0;
  localparam int FLAG_OVER_MAX  = 1;
  localparam int FLAG_AT_MIN    = 2;
  localparam int FLAG_UNDER_MIN = 3;

  function automatic int chan_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - one-hot round-robin grant with a rotating priority pointer
module round_robin_arbiter
  import saturating_accumulator_bank_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = chan_width(N)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic [N-1:0]  i_req,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);

  logic [IW-1:0] r_ptr;
  int            w_idx;

  // Scan from the pointer upward, wrapping, and take the first requester found.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = 0;
    for (int off = 0; off < N; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_enable && !o_grant_valid && i_req[w_idx]) begin
        o_grant_valid  = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = IW'(w_idx);
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_ptr <= '0;
    end else if (o_grant_valid) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/saturating_add_sub.sv
// rtl/saturating_add_sub.sv - signed add/subtract on one guard bit, clamped to caller-supplied limits
module saturating_add_sub
  import saturating_accumulator_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic                    i_sub,
  input  logic                    i_carry_in,
  input  logic signed [WIDTH-1:0] i_max,
  input  logic signed [WIDTH-1:0] i_min,
  output logic signed [WIDTH-1:0] o_result,
  output logic [FLAG_WIDTH-1:0]   o_flags
);

  logic signed [WIDTH:0] w_a_ext;
  logic signed [WIDTH:0] w_b_ext;
  logic signed [WIDTH:0] w_cin_ext;
  logic signed [WIDTH:0] w_max_ext;
  logic signed [WIDTH:0] w_min_ext;
  logic signed [WIDTH:0] w_sum;

  assign w_a_ext   = {i_a[WIDTH-1], i_a};
  assign w_b_ext   = {i_b[WIDTH-1], i_b};
  assign w_cin_ext = {{WIDTH{1'b0}}, i_carry_in};
  assign w_max_ext = {i_max[WIDTH-1], i_max};
  assign w_min_ext = {i_min[WIDTH-1], i_min};

  // Carry-in acts as a borrow when subtracting; the guard bit absorbs every overflow.
  assign w_sum = i_sub ? (w_a_ext - w_b_ext - w_cin_ext) : (w_a_ext + w_b_ext + w_cin_ext);

  always_comb begin
    o_result                = w_sum[WIDTH-1:0];
    o_flags                 = '0;
    o_flags[FLAG_AT_MAX]    = (w_sum == w_max_ext);
    o_flags[FLAG_AT_MIN]    = (w_sum == w_min_ext);
    if (w_sum > w_max_ext) begin
      o_result               = i_max;
      o_flags[FLAG_OVER_MAX] = 1'b1;
    end else if (w_sum < w_min_ext) begin
      o_result                = i_min;
      o_flags[FLAG_UNDER_MIN] = 1'b1;
    end
  end

endmodule

// File: rtl/saturating_accumulator_bank_scheduler.sv
// rtl/saturating_accumulator_bank_scheduler.sv - round-robin shared saturating datapath over per-channel accumulators
// Optional sticky saturation flags: SATURATING_ACCUMULATOR_BANK_STICKY_FLAGS_EN
module saturating_accumulator_bank_scheduler
  import saturating_accumulator_bank_pkg::*;
#(
  parameter int CHANNEL_COUNT = 4,
  parameter int WORD_WIDTH    = 16,
  localparam int CW = chan_width(CHANNEL_COUNT)
) (
  input  logic                                  clock,
  input  logic                                  clear,
  input  logic [WORD_WIDTH-1:0]                 max_limit,
  input  logic [WORD_WIDTH-1:0]                 min_limit,
  input  logic [CHANNEL_COUNT-1:0]              req_valid,
  output logic [CHANNEL_COUNT-1:0]              req_ready,
  input  logic [CHANNEL_COUNT-1:0]              req_load,
  input  logic [CHANNEL_COUNT-1:0]              req_add_sub,
  input  logic [CHANNEL_COUNT*WORD_WIDTH-1:0]   req_operand,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [CW-1:0]                         rsp_channel,
  output logic [WORD_WIDTH-1:0]                 rsp_value,
  output logic [FLAG_WIDTH-1:0]                 rsp_flags,
`ifdef SATURATING_ACCUMULATOR_BANK_STICKY_FLAGS_EN
  output logic [CHANNEL_COUNT*WORD_WIDTH-1:0]   acc_values,
  output logic [CHANNEL_COUNT-1:0]              sticky_saturated
`else
  output logic [CHANNEL_COUNT*WORD_WIDTH-1:0]   acc_values
`endif
);

  logic [CHANNEL_COUNT-1:0]     w_grant;
  logic [CW-1:0]                w_grant_idx;
  logic                         w_grant_valid;
  logic                         w_s1_advance;
  logic                         w_accept_en;
  logic                         w_grant_load;
  logic                         w_grant_sub;
  logic signed [WORD_WIDTH-1:0] w_grant_operand;

  logic                         r_s1_valid;
  logic [CW-1:0]                r_s1_ch;
  logic                         r_s1_load;
  logic                         r_s1_sub;
  logic signed [WORD_WIDTH-1:0] r_s1_operand;
  logic signed [WORD_WIDTH-1:0] r_s1_max;
  logic signed [WORD_WIDTH-1:0] r_s1_min;

  logic signed [WORD_WIDTH-1:0] r_acc [CHANNEL_COUNT];

  logic                         r_rsp_valid;
  logic [CW-1:0]                r_rsp_channel;
  logic [WORD_WIDTH-1:0]        r_rsp_value;
  logic [FLAG_WIDTH-1:0]        r_rsp_flags;

  logic signed [WORD_WIDTH-1:0] w_acc_sel;
  logic signed [WORD_WIDTH-1:0] w_dp_result;
  logic [FLAG_WIDTH-1:0]        w_dp_flags;
  logic signed [WORD_WIDTH-1:0] w_new_value;
  logic [FLAG_WIDTH-1:0]        w_new_flags;

  assign w_s1_advance = r_s1_valid & (~r_rsp_valid | rsp_ready);
  assign w_accept_en  = ~clear & (~r_s1_valid | w_s1_advance);

  round_robin_arbiter #(
    .N (CHANNEL_COUNT)
  ) u_arbiter (
    .clock         (clock),
    .clear         (clear),
    .i_req         (req_valid),
    .i_enable      (w_accept_en),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_grant_load    = 1'b0;
    w_grant_sub     = 1'b0;
    w_grant_operand = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (w_grant[i]) begin
        w_grant_load    = req_load[i];
        w_grant_sub     = req_add_sub[i];
        w_grant_operand = req_operand[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Limits are captured with the op so later limit changes cannot affect it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_s1_valid   <= 1'b0;
      r_s1_ch      <= '0;
      r_s1_load    <= 1'b0;
      r_s1_sub     <= 1'b0;
      r_s1_operand <= '0;
      r_s1_max     <= '0;
      r_s1_min     <= '0;
    end else if (w_grant_valid) begin
      r_s1_valid   <= 1'b1;
      r_s1_ch      <= w_grant_idx;
      r_s1_load    <= w_grant_load;
      r_s1_sub     <= w_grant_sub;
      r_s1_operand <= w_grant_operand;
      r_s1_max     <= max_limit;
      r_s1_min     <= min_limit;
    end else if (w_s1_advance) begin
      r_s1_valid   <= 1'b0;
    end
  end

  assign w_acc_sel = r_acc[r_s1_ch];

  saturating_add_sub #(
    .WIDTH (WORD_WIDTH)
  ) u_datapath (
    .i_a        (w_acc_sel),
    .i_b        (r_s1_operand),
    .i_sub      (r_s1_sub),
    .i_carry_in (1'b0),
    .i_max      (r_s1_max),
    .i_min      (r_s1_min),
    .o_result   (w_dp_result),
    .o_flags    (w_dp_flags)
  );

  always_comb begin
    w_new_value = w_dp_result;
    w_new_flags = w_dp_flags;
    if (r_s1_load) begin
      w_new_value = r_s1_operand;
      w_new_flags = '0;
    end
  end

  // Write-back lands on the same edge the next op enters stage 1, so no forwarding is needed.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) r_acc[i] <= '0;
    end else if (w_s1_advance) begin
      r_acc[r_s1_ch] <= w_new_value;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_channel <= '0;
      r_rsp_value   <= '0;
      r_rsp_flags   <= '0;
    end else if (w_s1_advance) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_channel <= r_s1_ch;
      r_rsp_value   <= w_new_value;
      r_rsp_flags   <= w_new_flags;
    end else if (rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_channel = r_rsp_channel;
  assign rsp_value   = r_rsp_value;
  assign rsp_flags   = r_rsp_flags;

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_acc_out
    assign acc_values[g*WORD_WIDTH +: WORD_WIDTH] = r_acc[g];
  end

`ifdef SATURATING_ACCUMULATOR_BANK_STICKY_FLAGS_EN
  logic [CHANNEL_COUNT-1:0] r_sticky;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_sticky <= '0;
    end else if (w_s1_advance) begin
      if (r_s1_load) begin
        r_sticky[r_s1_ch] <= 1'b0;
      end else if (w_new_flags[FLAG_OVER_MAX] | w_new_flags[FLAG_UNDER_MIN]) begin
        r_sticky[r_s1_ch] <= 1'b1;
      end
    end
  end

  assign sticky_saturated = r_sticky;
`endif

endmodule

// File: tb/tb_saturating_accumulator_bank_scheduler.sv
// tb/tb_saturating_accumulator_bank_scheduler.sv - randomized bench with a behavioural model of the accumulator bank
module tb_saturating_accumulator_bank_scheduler;

  logic        clock;
  logic        clear;
  logic [7:0]  max_limit;
  logic [7:0]  min_limit;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_load;
  logic [3:0]  req_add_sub;
  logic [31:0] req_operand;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_channel;
  logic [7:0]  rsp_value;
  logic [3:0]  rsp_flags;
  logic [31:0] acc_values;

  saturating_accumulator_bank_scheduler #(
    .CHANNEL_COUNT (4),
    .WORD_WIDTH    (8)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .max_limit   (max_limit),
    .min_limit   (min_limit),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_load    (req_load),
    .req_add_sub (req_add_sub),
    .req_operand (req_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_channel (rsp_channel),
    .rsp_value   (rsp_value),
    .rsp_flags   (rsp_flags),
    .acc_values  (acc_values)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int ch;
    bit ld;
    bit sub;
    int opnd;
    int mx;
    int mn;
  } op_t;

  int  n_pass  = 0;
  int  n_total = 0;

  int  m_acc [4];
  int  m_ptr;
  bit  m_s1;
  op_t m_s1_op;
  bit  m_rsp;
  int  m_rsp_ch;
  int  m_rsp_val;
  int  m_rsp_flags;

  logic [3:0] obs_ready;
  bit         obs_rsp_valid;
  int         obs_rsp_ch;
  int         obs_rsp_val;
  int         obs_rsp_flags;
  int         obs_acc [4];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    m_ptr = 0; m_s1 = 0; m_rsp = 0;
    m_rsp_ch = 0; m_rsp_val = 0; m_rsp_flags = 0;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int off = 0; off < 4; off++) begin
      if (v[(ptr + off) % 4]) return (ptr + off) % 4;
    end
    return -1;
  endfunction

  // Flag encoding {under_min, at_min, over_max, at_max} -> 8,4,2,1.
  function automatic void compute(input op_t o, input int a, output int res, output int fl);
    int s;
    fl = 0;
    if (o.ld) begin
      res = o.opnd;
      return;
    end
    s = o.sub ? a - o.opnd : a + o.opnd;
    res = s;
    if (s == o.mx) fl = fl | 1;
    if (s == o.mn) fl = fl | 4;
    if (s > o.mx) begin
      res = o.mx; fl = fl | 2;
    end else if (s < o.mn) begin
      res = o.mn; fl = fl | 8;
    end
  endfunction

  // One clock: compare DUT against the model, then advance the model over the edge.
  task automatic step();
    int g;
    bit adv;
    logic [3:0] exp_ready;
    int res, fl;
    #1;
    if (clear) model_reset();
    adv = m_s1 && (!m_rsp || rsp_ready);
    g = -1;
    if (!clear && (!m_s1 || adv)) g = rr_pick(req_valid, m_ptr);
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;

    obs_ready     = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_rsp_ch    = int'(rsp_channel);
    obs_rsp_val   = int'($signed(rsp_value));
    obs_rsp_flags = int'(rsp_flags);
    for (int i = 0; i < 4; i++) obs_acc[i] = int'($signed(acc_values[i*8 +: 8]));

    check("req_ready", int'(obs_ready), int'(exp_ready));
    check("rsp_valid", int'(obs_rsp_valid), int'(m_rsp));
    if (m_rsp) begin
      check("rsp_channel", obs_rsp_ch, m_rsp_ch);
      check("rsp_value", obs_rsp_val, m_rsp_val);
      check("rsp_flags", obs_rsp_flags, m_rsp_flags);
    end
    for (int i = 0; i < 4; i++) check($sformatf("acc%0d", i), obs_acc[i], m_acc[i]);

    @(posedge clock);
    if (!clear) begin
      if (adv) begin
        compute(m_s1_op, m_acc[m_s1_op.ch], res, fl);
        m_acc[m_s1_op.ch] = res;
        m_rsp = 1; m_rsp_ch = m_s1_op.ch; m_rsp_val = res; m_rsp_flags = fl;
      end else if (rsp_ready) begin
        m_rsp = 0;
      end
      if (g >= 0) begin
        m_s1 = 1;
        m_s1_op.ch   = g;
        m_s1_op.ld   = req_load[g];
        m_s1_op.sub  = req_add_sub[g];
        m_s1_op.opnd = int'($signed(req_operand[g*8 +: 8]));
        m_s1_op.mx   = int'($signed(max_limit));
        m_s1_op.mn   = int'($signed(min_limit));
        m_ptr = (g + 1) % 4;
      end else if (adv) begin
        m_s1 = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic set_op(input int ch, input bit ld, input bit sub, input int opnd);
    req_load[ch]           = ld;
    req_add_sub[ch]        = sub;
    req_operand[ch*8 +: 8] = 8'(opnd);
  endtask

  task automatic run_op(input int ch, input bit ld, input bit sub, input int opnd,
                        output int val, output int fl);
    bit got;
    val = 0; fl = 0;
    set_op(ch, ld, sub, opnd);
    req_valid = 4'(1 << ch);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = obs_ready[ch];
    end
    req_valid = '0;
    check("op_grant", int'(got), 1);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (obs_rsp_valid) begin
        got = 1; val = obs_rsp_val; fl = obs_rsp_flags;
      end
    end
    check("op_response", int'(got), 1);
  endtask

  initial begin
    int v, f, grants, seen, lo, hi, t;
    int exp_g [5] = '{1, 2, 4, 8, 1};
    int exp_c [5] = '{0, 1, 2, 3, 0};

    clear = 1'b1;
    max_limit = 8'sd100;
    min_limit = -8'sd100;
    req_valid = '0; req_load = '0; req_add_sub = '0; req_operand = '0;
    rsp_ready = 1'b1;
    model_reset();
    m_s1_op = '{0, 0, 0, 0, 0, 0};

    @(negedge clock);
    req_valid = 4'b1111;
    step();
    check("reset_req_ready", int'(obs_ready), 0);
    check("reset_rsp_valid", int'(obs_rsp_valid), 0);
    check("reset_rsp_value", obs_rsp_val, 0);
    for (int i = 0; i < 4; i++) check($sformatf("reset_acc%0d", i), obs_acc[i], 0);
    clear = 1'b0;
    req_valid = '0;

    for (int i = 0; i < 4; i++) set_op(i, 0, 0, 0);
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) req_valid = '0;
      step();
      if (k < 5) check("rr_grant", int'(obs_ready), exp_g[k]);
      if (k >= 2) begin
        check("rr_rsp_valid", int'(obs_rsp_valid), 1);
        check("rr_rsp_channel", obs_rsp_ch, exp_c[k-2]);
      end
    end

    run_op(0, 0, 0, 60, v, f);
    check("ch0_first_value", v, 60);
    check("ch0_first_flags", f, 0);
    run_op(0, 0, 0, 60, v, f);
    check("ch0_sat_value", v, 100);
    check("ch0_sat_flags", f, 2);
    step();
    check("ch0_acc", obs_acc[0], 100);

    run_op(1, 1, 0, -90, v, f);
    check("ch1_load_value", v, -90);
    check("ch1_load_flags", f, 0);
    run_op(1, 0, 1, 10, v, f);
    check("ch1_at_min_value", v, -100);
    check("ch1_at_min_flags", f, 4);
    run_op(1, 0, 1, 20, v, f);
    check("ch1_under_min_value", v, -100);
    check("ch1_under_min_flags", f, 8);

    set_op(2, 0, 0, 1);
    req_valid = 4'b0100;
    grants = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_ready[2]) grants++;
      if (grants == 5) req_valid = '0;
      if (obs_rsp_valid) begin
        seen++;
        check("ch2_burst_value", obs_rsp_val, seen);
      end
    end
    check("ch2_burst_count", seen, 5);
    check("ch2_acc", obs_acc[2], 5);

    set_op(3, 0, 0, 7);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    step();
    check("bp_grant_a", int'(obs_ready), 8);
    step();
    check("bp_grant_b", int'(obs_ready), 8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready_low", int'(obs_ready), 0);
      check("bp_rsp_held_valid", int'(obs_rsp_valid), 1);
      check("bp_rsp_held_value", obs_rsp_val, 7);
      check("bp_acc3_once", obs_acc[3], 7);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    check("bp_release_value", obs_rsp_val, 7);
    step();
    check("bp_second_value", obs_rsp_val, 14);
    check("bp_acc3_final", obs_acc[3], 14);

    for (int i = 0; i < 4; i++) set_op(i, 0, 0, 5);
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    clear = 1'b1;
    step();
    check("clr_rsp_valid", int'(obs_rsp_valid), 0);
    check("clr_req_ready", int'(obs_ready), 0);
    for (int i = 0; i < 4; i++) check($sformatf("clr_acc%0d", i), obs_acc[i], 0);
    clear = 1'b0;
    step();
    check("clr_next_grant", int'(obs_ready), 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 16 == 0) begin
        lo = int'($urandom_range(0, 255)) - 128;
        hi = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 3) == 0) hi = lo + int'($urandom_range(0, 20));
        if (hi > 127) hi = 127;
        if (hi < lo) begin
          t = hi; hi = lo; lo = t;
        end
        max_limit = 8'(hi);
        min_limit = 8'(lo);
      end
      req_valid = 4'($urandom);
      req_add_sub = 4'($urandom);
      for (int i = 0; i < 4; i++) req_load[i] = ($urandom_range(0, 7) == 0);
      req_operand = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 499) == 0);
      step();
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
